dcache_wt: RTL and testbench

//  Direct-mapped, write-through data cache between the datapath load/store port and a slow backing data memory.

---
 rtl/dcache_pkg.sv | 16 +
 rtl/dcache_array.sv | 45 ++++
 rtl/dcache_wt.sv | 122 ++++++++++++
 tb/tb_dcache_wt.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int DC_NBITS  = 8;
    localparam int DC_NLINES = 8;
    localparam int IDX       = $clog2(DC_NLINES);
    localparam int TAGW      = DC_NBITS - IDX - 2;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE,
        RESP
    } dcache_state_t;

endpackage

// File: rtl/dcache_array.sv
// Valid/tag/data storage: combinational read port, one write port, async valid clear.
module dcache_array #(
    parameter int DW = 8,
    parameter int IW = 3,
    parameter int TW = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [IW-1:0] i_ridx,
    output logic          o_valid,
    output logic [TW-1:0] o_tag,
    output logic [DW-1:0] o_data,
    input  logic          i_we,
    input  logic [IW-1:0] i_widx,
    input  logic [TW-1:0] i_wtag,
    input  logic [DW-1:0] i_wdata
);

    localparam int NL = 1 << IW;

    logic [NL-1:0] r_valid;
    logic [TW-1:0] r_tag  [NL];
    logic [DW-1:0] r_data [NL];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= '0;
        end else if (i_we) begin
            r_valid[i_widx] <= 1'b1;
        end
    end

    // Tag and data need no reset: they are meaningless while the valid bit is clear.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_tag[i_widx]  <= i_wtag;
            r_data[i_widx] <= i_wdata;
        end
    end

    assign o_valid = r_valid[i_ridx];
    assign o_tag   = r_tag[i_ridx];
    assign o_data  = r_data[i_ridx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through data cache; misses and all stores use a req/ack backing-memory port.
module dcache_wt
    import dcache_pkg::*;
#(
    parameter int NBITS  = DC_NBITS,
    parameter int NLINES = DC_NLINES
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NBITS-1:0] addr,
    input  logic [NBITS-1:0] wdata,
    input  logic             MemRead,
    input  logic             MemWrite,
    output logic [NBITS-1:0] rdata,
    output logic             busy,
    output logic             mem_req,
    output logic             mem_we,
    output logic [NBITS-1:0] mem_addr,
    output logic [NBITS-1:0] mem_wdata,
    input  logic [NBITS-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int A_IDX  = $clog2(NLINES);
    localparam int A_TAGW = NBITS - A_IDX - 2;

    dcache_state_t r_state, w_next;

    logic [NBITS-1:0]  r_addr, r_wdata, r_rdata;
    logic              r_we;
    logic [A_IDX-1:0]  w_idx;
    logic [A_TAGW-1:0] w_tag, w_line_tag;
    logic [NBITS-1:0]  w_line_data, w_arr_wdata;
    logic              w_line_valid, w_hit, w_arr_we, w_capture;

    // While a transaction is outstanding the lookup uses the captured address.
    assign w_idx = (r_state == IDLE) ? addr[A_IDX+1:2] : r_addr[A_IDX+1:2];
    assign w_tag = (r_state == IDLE) ? addr[NBITS-1:A_IDX+2] : r_addr[NBITS-1:A_IDX+2];
    assign w_hit = w_line_valid && (w_line_tag == w_tag);

    dcache_array #(
        .DW(NBITS),
        .IW(A_IDX),
        .TW(A_TAGW)
    ) u_array (
        .clock  (clock),
        .reset  (reset),
        .i_ridx (w_idx),
        .o_valid(w_line_valid),
        .o_tag  (w_line_tag),
        .o_data (w_line_data),
        .i_we   (w_arr_we),
        .i_widx (r_addr[A_IDX+1:2]),
        .i_wtag (r_addr[NBITS-1:A_IDX+2]),
        .i_wdata(w_arr_wdata)
    );

    assign w_capture = (r_state == IDLE) && (MemWrite || (MemRead && !w_hit));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            if (w_capture) begin
                r_addr  <= addr;
                r_wdata <= wdata;
                r_we    <= MemWrite;
            end
            if (r_state == FILL && mem_ack) begin
                r_rdata <= mem_rdata;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        busy        = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_wdata = mem_rdata;
        case (r_state)
            IDLE: begin
                if (MemWrite) begin
                    busy   = 1'b1;
                    w_next = WRITE;
                end else if (MemRead && !w_hit) begin
                    busy   = 1'b1;
                    w_next = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                if (mem_ack) begin
                    w_arr_we = 1'b1;
                    w_next   = RESP;
                end
            end
            WRITE: begin
                busy        = 1'b1;
                w_arr_wdata = r_wdata;
                if (mem_ack) begin
                    // No write-allocate: only a resident line is updated.
                    w_arr_we = w_hit;
                    w_next   = RESP;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign mem_req   = (r_state == FILL) || (r_state == WRITE);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign rdata     = (r_state == IDLE && MemRead && !MemWrite && w_hit) ? w_line_data : r_rdata;

endmodule

// File: tb/tb_dcache_wt.sv
// Directed vector bench for dcache_wt with a small responder for the backing-memory handshake.
module tb_dcache_wt;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] addr, wdata, rdata, mem_addr, mem_wdata, mem_rdata;
    logic       MemRead, MemWrite, busy, mem_req, mem_we, mem_ack;

    int n_vec  = 0;
    int n_chk  = 0;
    int n_miss = 0;

    always #5 clock = ~clock;

    dcache_wt #(.NBITS(8), .NLINES(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .addr     (addr),
        .wdata    (wdata),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .rdata    (rdata),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] wd;
        int         dly;       // cycles from first mem_req to mem_ack
        logic [7:0] fill;
        int         exp_busy;  // 0 means a hit with no backing access
        logic       exp_we;
        logic       chk_rd;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Entered and left at posedge+1; outputs are sampled at posedge+5.
    task automatic access(input vec_t v, input int k);
        int         bcyc, nreq, cnt;
        logic       seen, done, mwe;
        logic [7:0] maddr, mwd, rd_out;
        string      tg;
        tg = $sformatf("v%0d", k);
        bcyc = 0; nreq = 0; cnt = 0; seen = 0; done = 0;
        mwe = 0; maddr = 0; mwd = 0; rd_out = 0;
        n_vec++;
        addr = v.a; wdata = v.wd; MemRead = v.rd; MemWrite = v.wr;
        for (int c = 0; c < 60; c++) begin
            #4;
            if (!busy) begin
                rd_out = rdata;
                done = 1;
                break;
            end
            bcyc++;
            if (mem_req) begin
                if (!seen) begin
                    nreq++;
                    seen = 1;
                    maddr = mem_addr; mwe = mem_we; mwd = mem_wdata;
                end
                if (cnt == v.dly) begin
                    mem_ack = 1'b1;
                    mem_rdata = v.fill;
                end
                cnt++;
            end else begin
                seen = 0;
            end
            @(posedge clock); #1;
            mem_ack = 1'b0;
        end
        chk({tg, "_done"}, done, 1);
        chk({tg, "_busy_cycles"}, bcyc, v.exp_busy);
        chk({tg, "_nreq"}, nreq, (v.exp_busy > 0) ? 1 : 0);
        if (v.chk_rd) chk({tg, "_rdata"}, rd_out, v.exp_rd);
        if (nreq > 0) begin
            chk({tg, "_mem_addr"}, maddr, v.a);
            chk({tg, "_mem_we"}, mwe, v.exp_we);
            if (v.exp_we) chk({tg, "_mem_wdata"}, mwd, v.wd);
        end
        @(posedge clock); #1;
        MemRead = 0; MemWrite = 0;
        #4;
        chk({tg, "_post_req"}, mem_req, 0);
        chk({tg, "_post_busy"}, busy, 0);
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 0; addr = 0; wdata = 0; MemRead = 0; MemWrite = 0;
        mem_ack = 0; mem_rdata = 0;
        repeat (2) @(posedge clock);
        #1;
        n_vec++;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", rdata, 0);
        reset = 1;
        @(posedge clock); #1;

        // Spurious ack with no request outstanding
        n_vec++;
        mem_ack = 1; mem_rdata = 8'hEE;
        @(posedge clock); #1;
        mem_ack = 0;
        #3;
        chk("spur_busy", busy, 0);
        chk("spur_req", mem_req, 0);
        chk("spur_rdata", rdata, 0);
        @(posedge clock); #1;

        //             rd  wr  a      wd     dly fill   busy we   chk  exp
        vq.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 3, 8'h5A, 5, 1'b0, 1'b1, 8'h5A}); // cold miss
        vq.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h5A}); // hit
        vq.push_back('{1'b0, 1'b1, 8'h10, 8'h33, 1, 8'h00, 3, 1'b1, 1'b0, 8'h00}); // store hit
        vq.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h33}); // updated line
        vq.push_back('{1'b0, 1'b1, 8'h30, 8'h77, 0, 8'h00, 2, 1'b1, 1'b0, 8'h00}); // store miss
        vq.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h33}); // no allocate
        vq.push_back('{1'b1, 1'b0, 8'h30, 8'h00, 2, 8'h44, 4, 1'b0, 1'b1, 8'h44}); // conflict fill
        vq.push_back('{1'b1, 1'b0, 8'h10, 8'h00, 0, 8'h5A, 2, 1'b0, 1'b1, 8'h5A}); // evicted
        vq.push_back('{1'b1, 1'b0, 8'h30, 8'h00, 0, 8'h44, 2, 1'b0, 1'b1, 8'h44}); // evicted
        vq.push_back('{1'b1, 1'b1, 8'h08, 8'h99, 1, 8'hEE, 3, 1'b1, 1'b0, 8'h00}); // both set
        vq.push_back('{1'b1, 1'b0, 8'h08, 8'h00, 0, 8'h12, 2, 1'b0, 1'b1, 8'h12}); // not filled
        vq.push_back('{1'b1, 1'b0, 8'h08, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h12});
        vq.push_back('{1'b1, 1'b0, 8'h33, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h44}); // low bits ignored
        vq.push_back('{1'b0, 1'b1, 8'h0B, 8'hAB, 0, 8'h00, 2, 1'b1, 1'b0, 8'h00});
        vq.push_back('{1'b1, 1'b0, 8'h08, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'hAB});
        foreach (vq[i]) access(vq[i], i);

        // Asynchronous reset while a fill is outstanding
        n_vec++;
        addr = 8'h50; MemRead = 1;
        @(posedge clock); #1;
        chk("mid_fill_req", mem_req, 1);
        #2 reset = 0;
        #1 chk("mid_rst_req", mem_req, 0);
        MemRead = 0;
        #1 chk("mid_rst_busy", busy, 0);
        @(posedge clock); #1;
        reset = 1;
        mem_ack = 1; mem_rdata = 8'h66;
        @(posedge clock); #1;
        mem_ack = 0;
        #3;
        chk("late_ack_busy", busy, 0);
        chk("late_ack_req", mem_req, 0);
        chk("late_ack_rdata", rdata, 0);
        @(posedge clock); #1;

        vq.delete();
        vq.push_back('{1'b1, 1'b0, 8'h30, 8'h00, 0, 8'h44, 2, 1'b0, 1'b1, 8'h44}); // lines cleared
        vq.push_back('{1'b1, 1'b0, 8'h08, 8'h00, 1, 8'h21, 3, 1'b0, 1'b1, 8'h21});
        vq.push_back('{1'b1, 1'b0, 8'h50, 8'h00, 2, 8'h67, 4, 1'b0, 1'b1, 8'h67});
        vq.push_back('{1'b1, 1'b0, 8'h50, 8'h00, 0, 8'h00, 0, 1'b0, 1'b1, 8'h67});
        foreach (vq[i]) access(vq[i], 100 + i);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
